gate_activation: RTL and testbench
==================================

# gate_activation

Element-serial activation stage directly downstream of the gate dot-product unit. On each `dataReady` pulse it captures the NROW-element matrix-vector result and adds a per-row bias with saturation. It then applies a piecewise-linear sigmoid or tanh to one element per cycle. The activated vector is presented with a one-cycle `outputValid` pulse, ready for the LSTM cell-state / hidden-state update logic.

## Interface
- `NROW`, 16, number of vector elements (gate rows)
- `QN`, 6, integer bits of the Q-format
- `QM`, 11, fractional bits; `BITWIDTH = QN+QM+1` (18), 1.0 = 2^QM = 2048
- `ACT_TYPE`, 0, 0 = sigmoid, 1 = tanh (elaboration-time choice)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `dataReady`  in  1  one-cycle pulse from the dot-product unit; `inputVector` is valid in the same cycle
- `inputVector`  in  BITWIDTH*NROW  signed dot-product results; element k at `[k*BITWIDTH +: BITWIDTH]`
- `bias`  in  BITWIDTH*NROW  signed per-row bias, same packing; sampled with `inputVector`
- `outputVector`  out  BITWIDTH*NROW  signed activated results, same packing; register
- `outputValid`  out  1  one-cycle pulse; `outputVector` holds the new result in this cycle
- `busy`  out  1  high while a vector is being processed
- `overrun`  out  1  one-cycle pulse when `dataReady` arrives while not in IDLE

## Operation
- States: IDLE, PROC, DRAIN, DONE.
  - IDLE→PROC on `dataReady`.
  - PROC→DRAIN when `idx == NROW-1`.
  - DRAIN→DONE unconditionally.
  - DONE→IDLE unconditionally.
- Capture in IDLE with `dataReady`: latch `inputVector` and `bias` into internal `inReg` and `biasReg`, and set `idx = 0`.
- PROC, cycle for `idx`:
  - `sumReg <= sat(in[idx] + bias[idx])`, computed at BITWIDTH+1 bits and clamped to [-2^17, 2^17-1].
  - `idx` increments by 1 each cycle.
- Stage 2 runs in the cycle after each PROC issue, including DRAIN. It computes `act(sumReg)` and writes it into element `idx-1` of the internal `workReg`.
- Sigmoid `s(x)`, with `a = |x|` (a of -2^17 saturates to 2^17-1):
  - a ≥ 10240: p = 2048.
  - 4864 ≤ a < 10240: p = (a>>>5) + 1728.
  - 2048 ≤ a < 4864: p = (a>>>3) + 1280.
  - a < 2048: p = (a>>>2) + 1024.
  - Result: s = p if x ≥ 0, else 2048 − p.
- Tanh: `t(x) = 2*s(sat(2x)) − 2048`, where `sat(2x)` clamps to the 18-bit range. Result lies in [-2048, 2048].
- All shifts truncate (floor) and there is no rounding. Results always fit in BITWIDTH.
- On the edge ending DRAIN, with the last element's stage-2 result merged in:
  - `outputVector <= workReg`.
  - `outputValid <= 1` for exactly one cycle (the DONE cycle).
- `outputVector` is stable between `outputValid` pulses. Partial results are never visible on it.
- `dataReady` in PROC, DRAIN or DONE:
  - The vector is dropped.
  - `overrun` pulses in the following cycle.
  - The current computation is unaffected.

## Timing
- `dataReady` in cycle T:
  - PROC spans T+1 … T+NROW.
  - DRAIN is T+NROW+1.
  - `outputValid` is high in T+NROW+2.
- Latency `dataReady` → `outputValid` is NROW+2 cycles (18 at defaults).
- Next `dataReady` is accepted from T+NROW+3 onward.
- Minimum input period is NROW+3 cycles. The dot-product unit's period of NCOL*DSP48_PER_ROW+1 = 33 cycles at defaults satisfies this.
- `busy` is high T+1 … T+NROW+2.
- Reset values, applied on a reset edge in any state including mid-vector:
  - state IDLE, `idx` 0.
  - `outputVector` 0, `outputValid` 0, `busy` 0, `overrun` 0.
  - `inReg`, `biasReg`, `sumReg`, `workReg` 0.
  - A partially processed vector is discarded and no `outputValid` is produced.
- `dataReady` asserted together with `reset` is ignored.

## Test plan
- Sigmoid, bias 0, inputs [0, 2048, −2048, 4864, 12000, −131072, …] → outputs [1024, 1536, 512, 1880, 2048, 0]; `outputValid` exactly 18 cycles after `dataReady`.
- Tanh build, bias 0, inputs [0, 1024, −1024, 70000] → [0, 1024, −1024, 2048].
- Bias saturation: input 131000 plus bias 1000 → sum clamps to 131071 → sigmoid 2048. Input −131000 plus bias −1000 → 0.
- Back-to-back: second `dataReady` at T+10 → `overrun` pulses at T+11, first result is unchanged at T+18. Second `dataReady` at T+19 → accepted, valid at T+37.
- `reset` at T+8 mid-PROC → all outputs 0 next cycle and no `outputValid`. A new `dataReady` at T+12 → valid at T+30 with correct values.
- Stability: `outputVector` is unchanged from one `outputValid` through the whole next processing run until the next `outputValid`.

Source files
------------

// File: rtl/gate_activation.sv
// Element-serial bias-add and piecewise-linear activation stage for one LSTM gate.
// Captures a full dot-product vector, then activates one element per cycle through a two-stage pipe.
//
// state | meaning
// IDLE  | waiting for dataReady; capture inputVector and bias on it
// PROC  | stage 1: saturating bias add for element idx; stage 2 activates idx-1
// DRAIN | stage 2 activates the last element; result copied to outputVector
// DONE  | outputValid high for this single cycle
module gate_activation #(
    parameter int NROW     = 16,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int ACT_TYPE = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dataReady,
    input  logic [(QN+QM+1)*NROW-1:0]      inputVector,
    input  logic [(QN+QM+1)*NROW-1:0]      bias,
    output logic [(QN+QM+1)*NROW-1:0]      outputVector,
    output logic                           outputValid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int BW      = QN + QM + 1;
    localparam int VW      = BW * NROW;
    localparam int IW      = $clog2(NROW + 1);
    localparam int ONE     = 1 << QM;
    localparam int BP_HI   = 5 * ONE;
    localparam int BP_MID  = (19 * ONE) / 8;
    localparam int OFF_HI  = (27 * ONE) / 32;
    localparam int OFF_MID = (5 * ONE) / 8;
    localparam int OFF_LO  = ONE / 2;

    localparam logic signed [BW-1:0] MAXV = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] MINV = {1'b1, {(BW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PROC, DRAIN, DONE} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [VW-1:0]          inReg;
    logic [VW-1:0]          biasReg;
    logic [VW-1:0]          workReg;
    logic signed [BW-1:0]   sumReg;

    logic signed [BW-1:0]   in_sel;
    logic signed [BW-1:0]   bias_sel;
    logic signed [BW-1:0]   act_val;
    logic [VW-1:0]          work_next;
    logic                   wr_en;
    logic [IW-1:0]          wr_idx;

    function automatic logic signed [BW-1:0] sat_add(input logic signed [BW-1:0] a,
                                                     input logic signed [BW-1:0] b);
        logic [BW:0] s;
        s = {a[BW-1], a} + {b[BW-1], b};
        if (s[BW] != s[BW-1])
            return s[BW] ? MINV : MAXV;
        return $signed(s[BW-1:0]);
    endfunction

    function automatic logic signed [BW-1:0] sigmoid(input logic signed [BW-1:0] x);
        logic [BW-1:0] a;
        logic [BW-1:0] p;
        if (x == MINV)
            a = MAXV;
        else if (x[BW-1])
            a = -x;
        else
            a = x;
        if (a >= BW'(BP_HI))
            p = BW'(ONE);
        else if (a >= BW'(BP_MID))
            p = (a >> 5) + BW'(OFF_HI);
        else if (a >= BW'(ONE))
            p = (a >> 3) + BW'(OFF_MID);
        else
            p = (a >> 2) + BW'(OFF_LO);
        return x[BW-1] ? $signed(BW'(ONE) - p) : $signed(p);
    endfunction

    // tanh(x) = 2*sigmoid(2x) - 1, with 2x saturated to the word range
    function automatic logic signed [BW-1:0] activate(input logic signed [BW-1:0] x);
        logic signed [BW-1:0] s;
        if (ACT_TYPE == 1) begin
            s = sigmoid(sat_add(x, x));
            return s + s - BW'(ONE);
        end
        return sigmoid(x);
    endfunction

    assign wr_en  = ((state == PROC) && (idx != '0)) || (state == DRAIN);
    assign wr_idx = idx - IW'(1);

    always_comb begin
        in_sel    = '0;
        bias_sel  = '0;
        work_next = workReg;
        act_val   = activate(sumReg);
        for (int k = 0; k < NROW; k++) begin
            if (idx == IW'(k)) begin
                in_sel   = inReg[k*BW +: BW];
                bias_sel = biasReg[k*BW +: BW];
            end
            if (wr_en && (wr_idx == IW'(k)))
                work_next[k*BW +: BW] = act_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            inReg        <= '0;
            biasReg      <= '0;
            sumReg       <= '0;
            workReg      <= '0;
            outputVector <= '0;
            outputValid  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            outputValid <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (dataReady) begin
                        inReg   <= inputVector;
                        biasReg <= bias;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= PROC;
                    end
                end
                PROC: begin
                    overrun <= dataReady;
                    sumReg  <= sat_add(in_sel, bias_sel);
                    workReg <= work_next;
                    idx     <= idx + IW'(1);
                    if (idx == IW'(NROW - 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    overrun      <= dataReady;
                    workReg      <= work_next;
                    outputVector <= work_next;
                    outputValid  <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    overrun <= dataReady;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_activation.sv
// Directed bench for gate_activation: sigmoid and tanh builds side by side on shared stimulus.
module tb_gate_activation;

    localparam int NROW = 16;
    localparam int BW   = 18;
    localparam int VW   = BW * NROW;

    logic          clk = 1'b0;
    logic          reset;
    logic          dataReady;
    logic [VW-1:0] inputVector;
    logic [VW-1:0] bias;
    logic [VW-1:0] ov_s, ov_t;
    logic          valid_s, busy_s, ovr_s;
    logic          valid_t, busy_t, ovr_t;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_activation #(.NROW(NROW), .QN(6), .QM(11), .ACT_TYPE(0)) u_sig (
        .clk(clk), .reset(reset), .dataReady(dataReady),
        .inputVector(inputVector), .bias(bias),
        .outputVector(ov_s), .outputValid(valid_s), .busy(busy_s), .overrun(ovr_s)
    );

    gate_activation #(.NROW(NROW), .QN(6), .QM(11), .ACT_TYPE(1)) u_tanh (
        .clk(clk), .reset(reset), .dataReady(dataReady),
        .inputVector(inputVector), .bias(bias),
        .outputVector(ov_t), .outputValid(valid_t), .busy(busy_t), .overrun(ovr_t)
    );

    int in1[NROW]  = '{0, 2048, -2048, 4864, 12000, -131072, 1024, -1024,
                       70000, 100, -100, 3000, -5000, 10239, 10240, -3};
    int sig1[NROW] = '{1024, 1536, 512, 1880, 2048, 0, 1280, 768,
                       2048, 1049, 999, 1655, 164, 2047, 2048, 1024};
    int tan1[NROW] = '{0, 1536, -1536, 2016, 2048, -2048, 1024, -1024,
                       2048, 100, -100, 1782, -2032, 2048, 2048, -2};
    int zero[NROW] = '{default: 0};

    // bias saturation in both directions plus a few ordinary sums
    int in2[NROW]  = '{131000, -131000, 1000, -500, 2000, -131072, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
    int b2[NROW]   = '{1000, -1000, 1048, 500, -3000, 131071, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
    int sig2[NROW] = '{2048, 0, 1536, 1024, 774, 1024, 1024, 1024,
                       1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
    int tan2[NROW] = '{2048, -2048, 1536, 0, -1000, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
    int junk[NROW] = '{default: 5000};

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack(input int v[NROW]);
        logic [VW-1:0] r;
        int            t;
        r = '0;
        for (int k = 0; k < NROW; k++) begin
            t = v[k];
            r[k*BW +: BW] = t[BW-1:0];
        end
        return r;
    endfunction

    task automatic check_vec(input string tag, input int es[NROW], input int et[NROW]);
        for (int k = 0; k < NROW; k++) begin
            check($sformatf("%s sig[%0d]", tag, k), int'($signed(ov_s[k*BW +: BW])), es[k]);
            check($sformatf("%s tanh[%0d]", tag, k), int'($signed(ov_t[k*BW +: BW])), et[k]);
        end
    endtask

    // called on a falling edge; returns on the falling edge of cycle T+1
    task automatic start(input logic [VW-1:0] v, input logic [VW-1:0] b);
        inputVector = v;
        bias        = b;
        dataReady   = 1'b1;
        @(negedge clk);
        dataReady   = 1'b0;
    endtask

    // n counts the current cycle as 1; outputVector must hold prev until valid
    task automatic wait_valid(input string tag, input int exp_n,
                              input logic [VW-1:0] prev_s, input logic [VW-1:0] prev_t);
        int n;
        int stable;
        n      = 1;
        stable = 1;
        while (!valid_s && n < 40) begin
            if (ov_s !== prev_s || ov_t !== prev_t)
                stable = 0;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, exp_n);
        check({tag, " tanh valid"}, int'(valid_t), 1);
        check({tag, " stable"}, stable, 1);
    endtask

    initial begin
        reset       = 1'b1;
        dataReady   = 1'b0;
        inputVector = '0;
        bias        = '0;
        repeat (3) @(negedge clk);
        check("reset ov", int'(ov_s != '0 || ov_t != '0), 0);
        check("reset valid", int'(valid_s), 0);
        check("reset busy", int'(busy_s), 0);
        check("reset overrun", int'(ovr_s), 0);
        reset = 1'b0;
        @(negedge clk);

        // basic vector, bias zero
        start(pack(in1), pack(zero));
        check("run1 busy", int'(busy_s), 1);
        wait_valid("run1", 18, '0, '0);
        check_vec("run1", sig1, tan1);
        @(negedge clk);
        check("run1 pulse", int'(valid_s), 0);
        check("run1 busy end", int'(busy_s), 0);

        // overrun at T+10 is dropped; result of the accepted vector is intact
        start(pack(in2), pack(b2));
        repeat (9) @(negedge clk);
        inputVector = pack(junk);
        bias        = pack(junk);
        dataReady   = 1'b1;
        @(negedge clk);
        dataReady   = 1'b0;
        check("ovr pulse sig", int'(ovr_s), 1);
        check("ovr pulse tanh", int'(ovr_t), 1);
        @(negedge clk);
        check("ovr clear", int'(ovr_s), 0);
        wait_valid("run2", 7, pack(sig1), pack(tan1));
        check_vec("run2", sig2, tan2);
        @(negedge clk);
        check("run2 pulse", int'(valid_s), 0);

        // accepted at T+19
        start(pack(in1), pack(zero));
        wait_valid("run3", 18, pack(sig2), pack(tan2));
        check_vec("run3", sig1, tan1);
        @(negedge clk);

        // reset mid-PROC at T+8, with dataReady asserted alongside it
        start(pack(in2), pack(b2));
        repeat (7) @(negedge clk);
        reset       = 1'b1;
        dataReady   = 1'b1;
        inputVector = pack(in1);
        bias        = pack(zero);
        @(negedge clk);
        reset     = 1'b0;
        dataReady = 1'b0;
        check("midrst ov", int'(ov_s != '0 || ov_t != '0), 0);
        check("midrst valid", int'(valid_s), 0);
        check("midrst busy", int'(busy_s), 0);
        check("midrst overrun", int'(ovr_s), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("midrst idle valid %0d", c), int'(valid_s), 0);
            check($sformatf("midrst idle busy %0d", c), int'(busy_s), 0);
        end
        @(negedge clk);
        start(pack(in1), pack(zero));
        wait_valid("run4", 18, '0, '0);
        check_vec("run4", sig1, tan1);
        @(negedge clk);
        check("run4 pulse", int'(valid_s), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
